uart_prog_loader: RTL and testbench

- Sequences program download from the UART receiver into the 6502 system RAM and arbitrates the single RAM port between the loader and the CPU.
- While a download is in progress, the CPU is held in reset and the loader owns the RAM port.
- After the byte stream goes idle, the CPU is released from reset and starts executing from the load base (the reset vector already points there).

---
 rtl/uart_prog_loader.sv | 135 +++++++++++++
 tb/tb_uart_prog_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// Program download sequencer: streams UART bytes into RAM from LOAD_BASE while
// holding the CPU in reset, then hands the single RAM port back to the CPU.
module uart_prog_loader #(
    parameter logic [15:0] LOAD_BASE  = 16'h0600,
    parameter int          MAX_LEN    = 1024,
    parameter int          LEN_W      = 11,
    parameter int          TIMEOUT    = 50000,
    parameter int          RESET_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic [15:0]      cpu_addr,
    input  logic [7:0]       cpu_wdata,
    input  logic             cpu_we,
    output logic [15:0]      mem_addr,
    output logic [7:0]       mem_wdata,
    output logic             mem_we,
    output logic             cpu_rst,
    output logic             loading,
    output logic [LEN_W-1:0] load_count,
    output logic             overflow
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int HOLD_W = $clog2(RESET_HOLD + 1);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RUN,
        ST_LOAD
    } state_t;

    state_t             state_q;
    logic               cpu_rst_q;
    logic               loading_q;
    logic [LEN_W-1:0]   load_count_q;
    logic               overflow_q;
    logic               ld_we_q;
    logic [15:0]        ld_addr_q;
    logic [7:0]         ld_wdata_q;
    logic [IDLE_W-1:0]  idle_q;
    logic [HOLD_W-1:0]  hold_q;

    // A write still in flight has not yet bumped load_count, so back-to-back
    // bytes must see the count including it.
    logic [LEN_W-1:0]   count_eff_d;
    logic               room_d;
    logic [15:0]        wr_addr_d;
    logic               start_d;

    assign count_eff_d = load_count_q + LEN_W'(ld_we_q);
    assign room_d      = count_eff_d < LEN_W'(MAX_LEN);
    assign wr_addr_d   = LOAD_BASE + 16'(count_eff_d);
    assign start_d     = rx_valid && (state_q != ST_LOAD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_HOLD;
            cpu_rst_q    <= 1'b1;
            loading_q    <= 1'b0;
            load_count_q <= '0;
            overflow_q   <= 1'b0;
            ld_we_q      <= 1'b0;
            ld_addr_q    <= LOAD_BASE;
            ld_wdata_q   <= 8'h00;
            idle_q       <= '0;
            hold_q       <= '0;
        end else begin
            ld_we_q      <= 1'b0;
            load_count_q <= count_eff_d;
            if (start_d) begin
                // First byte of a new download is always written at LOAD_BASE.
                state_q      <= ST_LOAD;
                cpu_rst_q    <= 1'b1;
                loading_q    <= 1'b1;
                load_count_q <= '0;
                overflow_q   <= 1'b0;
                ld_we_q      <= 1'b1;
                ld_addr_q    <= LOAD_BASE;
                ld_wdata_q   <= rx_data;
                idle_q       <= '0;
            end else begin
                case (state_q)
                    ST_HOLD: begin
                        if (hold_q == HOLD_W'(RESET_HOLD - 1)) begin
                            state_q   <= ST_RUN;
                            cpu_rst_q <= 1'b0;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        cpu_rst_q <= 1'b0;
                    end
                    ST_LOAD: begin
                        if (rx_valid) begin
                            idle_q <= '0;
                            if (room_d) begin
                                ld_we_q    <= 1'b1;
                                ld_addr_q  <= wr_addr_d;
                                ld_wdata_q <= rx_data;
                            end else begin
                                overflow_q <= 1'b1;
                            end
                        end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                            state_q   <= ST_HOLD;
                            loading_q <= 1'b0;
                            hold_q    <= '0;
                        end else begin
                            idle_q <= idle_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= ST_HOLD;
                        cpu_rst_q <= 1'b1;
                        loading_q <= 1'b0;
                        hold_q    <= '0;
                    end
                endcase
            end
        end
    end

    // Only RUN exposes the CPU bus to RAM; everything else is registered.
    assign mem_addr   = (state_q == ST_RUN) ? cpu_addr  : ld_addr_q;
    assign mem_wdata  = (state_q == ST_RUN) ? cpu_wdata : ld_wdata_q;
    assign mem_we     = (state_q == ST_RUN) ? cpu_we    : ld_we_q;
    assign cpu_rst    = cpu_rst_q;
    assign loading    = loading_q;
    assign load_count = load_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: directed downloads with a write scoreboard that
// checks address, data and the exact cycle of every RAM write.
module tb_uart_prog_loader;

    localparam int T   = 100;
    localparam int R   = 4;
    localparam int MAX = 6;
    localparam int LW  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [15:0]   cpu_addr = 16'h0000;
    logic [7:0]    cpu_wdata = 8'h00;
    logic          cpu_we = 1'b0;
    logic [15:0]   mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic          cpu_rst;
    logic          loading;
    logic [LW-1:0] load_count;
    logic          overflow;

    uart_prog_loader #(
        .LOAD_BASE (16'h0600),
        .MAX_LEN   (MAX),
        .LEN_W     (LW),
        .TIMEOUT   (T),
        .RESET_HOLD(R)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .cpu_rst   (cpu_rst),
        .loading   (loading),
        .load_count(load_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [7:0] d, input int c);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.cyc  = c;
        exp_q.push_back(w);
    endtask

    // Drives one rx strobe in the current cycle; an accepted byte must appear
    // on the RAM port exactly one cycle later.
    task automatic send_byte(input logic [7:0] b, input logic [15:0] a, input bit expect_wr);
        rx_data  = b;
        rx_valid = 1'b1;
        if (expect_wr) push(a, b, cyc + 1);
        tick();
        rx_valid = 1'b0;
    endtask

    // Called in the cycle after the last byte was strobed.
    task automatic check_release(input string tag);
        repeat (T + R - 1) tick();
        chk({tag, "_rst_still_high"}, cpu_rst, 1'b1);
        chk({tag, "_loading_low"}, loading, 1'b0);
        tick();
        chk({tag, "_rst_released"}, cpu_rst, 1'b0);
    endtask

    // Monitor: every RAM write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mem_we) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL write_unexpected: got %04h=%02h at cycle %0d, required no write",
                         mem_addr, mem_wdata, cyc);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                if (mem_addr !== w.addr || mem_wdata !== w.data || cyc != w.cyc) begin
                    fails++;
                    $display("FAIL write_match: got %04h=%02h at cycle %0d, required %04h=%02h at cycle %0d",
                             mem_addr, mem_wdata, cyc, w.addr, w.data, w.cyc);
                end
            end
        end
    end

    logic [7:0] prog [6];
    logic [7:0] b;

    initial begin
        prog[0] = 8'hA0; prog[1] = 8'h00; prog[2] = 8'hC8;
        prog[3] = 8'h4C; prog[4] = 8'h02; prog[5] = 8'h06;

        // Reset state
        repeat (3) tick();
        chk("rst_cpu_rst", cpu_rst, 1'b1);
        chk("rst_loading", loading, 1'b0);
        chk("rst_count", load_count, '0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);

        // Reset release: cpu_rst stays high for R cycles
        reset = 1'b0;
        chk("hold_c0", cpu_rst, 1'b1);
        for (int i = 1; i < R; i++) begin
            tick();
            chk("hold_cn", cpu_rst, 1'b1);
        end
        tick();
        chk("run_cpu_rst", cpu_rst, 1'b0);

        // RUN mux is combinational
        cpu_addr = 16'h1234; cpu_wdata = 8'h55; #1;
        chk("mux_addr", mem_addr, 16'h1234);
        chk("mux_wdata", mem_wdata, 8'h55);
        chk("mux_we", mem_we, 1'b0);
        cpu_addr = 16'h0300; cpu_wdata = 8'h11; cpu_we = 1'b1;
        push(16'h0300, 8'h11, cyc);
        tick();
        cpu_we = 1'b0;
        tick();

        // Six-byte program download with idle gaps; CPU writes must be ignored
        send_byte(prog[0], 16'h0600, 1'b1);
        chk("dl_cpu_rst_rise", cpu_rst, 1'b1);
        chk("dl_loading", loading, 1'b1);
        cpu_addr = 16'h0400; cpu_wdata = 8'hEE; cpu_we = 1'b1;
        for (int i = 1; i < 6; i++) begin
            repeat (20) tick();
            send_byte(prog[i], 16'h0600 + 16'(i), 1'b1);
        end
        cpu_we = 1'b0;
        tick();
        chk("dl_count", load_count, 4'd6);
        chk("dl_overflow", overflow, 1'b0);
        repeat (T + R - 2) tick();
        chk("dl_rst_still_high", cpu_rst, 1'b1);
        tick();
        chk("dl_rst_released", cpu_rst, 1'b0);
        chk("dl_count_kept", load_count, 4'd6);

        // Back-to-back bytes
        send_byte(8'h11, 16'h0600, 1'b1);
        send_byte(8'h22, 16'h0601, 1'b1);
        send_byte(8'h33, 16'h0602, 1'b1);
        tick();
        chk("b2b_count", load_count, 4'd3);
        repeat (T + R + 5) tick();
        chk("b2b_released", cpu_rst, 1'b0);

        // Overflow: MAX bytes written, the rest dropped but still restart idle
        for (int i = 0; i < MAX + 2; i++) begin
            if (i != 0) repeat (2) tick();
            b = 8'h80 + 8'(i);
            send_byte(b, 16'h0600 + 16'(i), i < MAX);
        end
        chk("ovf_count", load_count, 4'(MAX));
        chk("ovf_flag", overflow, 1'b1);
        check_release("ovf");
        chk("ovf_sticky", overflow, 1'b1);
        send_byte(8'h77, 16'h0600, 1'b1);
        chk("newdl_ovf_clear", overflow, 1'b0);
        chk("newdl_count_clear", load_count, 4'd0);
        tick();
        chk("newdl_count", load_count, 4'd1);
        repeat (T + R + 5) tick();

        // CPU write and rx strobe in the same RUN cycle
        cpu_addr = 16'h0200; cpu_wdata = 8'h99; cpu_we = 1'b1;
        push(16'h0200, 8'h99, cyc);
        send_byte(8'h5A, 16'h0600, 1'b1);
        tick();
        cpu_we = 1'b0;
        repeat (T + R + 5) tick();
        chk("same_cycle_released", cpu_rst, 1'b0);

        // Reset in the middle of a download cancels the pending write at once
        send_byte(8'hE1, 16'h0600, 1'b1);
        tick();
        send_byte(8'hE2, 16'h0601, 1'b1);
        tick();
        send_byte(8'hE3, 16'h0602, 1'b1);
        tick();
        send_byte(8'hE4, 16'h0603, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_mem_we", mem_we, 1'b0);
        chk("midrst_cpu_rst", cpu_rst, 1'b1);
        chk("midrst_count", load_count, '0);
        chk("midrst_loading", loading, 1'b0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        send_byte(8'hF1, 16'h0600, 1'b1);
        tick();
        send_byte(8'hF2, 16'h0601, 1'b1);
        repeat (2) tick();
        chk("fresh_count", load_count, 4'd2);
        repeat (T + R + 5) tick();
        chk("fresh_released", cpu_rst, 1'b0);
        chk("sb_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
